// File: rtl/branch_pkg.sv
// Shared types and helpers for the pipelined branch target unit.
package branch_pkg;

    typedef enum logic [1:0] {
        BT_REL  = 2'd0,
        BT_ABS  = 2'd1,
        BT_REG  = 2'd2,
        BT_RSVD = 2'd3
    } bt_mode_e;

    localparam int unsigned MAX_W = 64;

    // Signed working width: room for the larger operand plus carry and sign.
    function automatic int unsigned sw_of(input int unsigned pc_w,
                                          input int unsigned imm_w,
                                          input int unsigned shift);
        return ((pc_w > imm_w + shift) ? pc_w : imm_w + shift) + 2;
    endfunction

    // Sign-extend an imm_w-bit immediate held in the low bits, then scale it.
    function automatic logic signed [MAX_W-1:0] sext_shift(input logic [MAX_W-1:0] imm,
                                                           input int unsigned imm_w,
                                                           input int unsigned shift);
        logic signed [MAX_W-1:0] v;
        v = $signed(imm << (MAX_W - imm_w));
        v = v >>> (MAX_W - imm_w);
        return v <<< shift;
    endfunction

endpackage

// File: rtl/branch_target_unit_pipe_stage.sv
// Generic valid/ready register slice with flush; no skid buffer.
module bt_pipe_stage #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         up_valid,
    output logic         up_ready_c,
    input  logic [W-1:0] up_data,
    output logic         dn_valid,
    input  logic         dn_ready,
    output logic [W-1:0] dn_data
);

    logic load;

    assign up_ready_c = !dn_valid || dn_ready;
    assign load       = up_valid && up_ready_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dn_valid <= 1'b0;
            dn_data  <= '0;
        end else begin
            if (flush)         dn_valid <= 1'b0;
            else if (load)     dn_valid <= 1'b1;
            else if (dn_ready) dn_valid <= 1'b0;
            if (load) dn_data <= up_data;
        end
    end

endmodule

// File: rtl/branch_target_unit.sv
// Two-stage branch target calculator: operand select/scale, then add and wrap detect.
module branch_target_unit
    import branch_pkg::*;
#(
    parameter int unsigned PC_W  = 8,
    parameter int unsigned IMM_W = 16,
    parameter int unsigned SHIFT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [IMM_W-1:0] immediate,
    input  logic [PC_W-1:0]  program_counter,
    input  logic [PC_W-1:0]  reg_base,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PC_W-1:0]  BT,
    output logic             wrap,
    output logic             illegal
);

    localparam int unsigned SW   = sw_of(PC_W, IMM_W, SHIFT);
    localparam int unsigned P1_W = 2 + PC_W + SW;
    localparam int unsigned P2_W = PC_W + 2;

    bt_mode_e              in_mode;
    logic [PC_W-1:0]       in_base;
    logic signed [SW-1:0]  in_off;
    logic [P1_W-1:0]       s1_in;
    logic [P1_W-1:0]       s1_data;
    logic                  s1_valid;
    logic                  s2_ready;
    logic [1:0]            s1_mode_raw;
    bt_mode_e              s1_mode;
    logic [PC_W-1:0]       s1_base;
    logic signed [SW-1:0]  s1_off;
    logic signed [SW-1:0]  exact;
    logic                  s1_wrap;
    logic [P2_W-1:0]       s2_in;
    logic [P2_W-1:0]       s2_data;

    // Stage 1 operands: reserved mode falls back to PC-relative.
    always_comb begin
        in_mode = bt_mode_e'(mode);
        in_base = (in_mode == BT_REG) ? reg_base : program_counter;
        in_off  = SW'(sext_shift(MAX_W'(immediate), IMM_W, SHIFT));
    end

    assign s1_in = {mode, in_base, in_off};

    bt_pipe_stage #(.W(P1_W)) u_stage1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .up_valid   (in_valid),
        .up_ready_c (in_ready),
        .up_data    (s1_in),
        .dn_valid   (s1_valid),
        .dn_ready   (s2_ready),
        .dn_data    (s1_data)
    );

    assign {s1_mode_raw, s1_base, s1_off} = s1_data;
    assign s1_mode = bt_mode_e'(s1_mode_raw);

    // Exact signed target; anything beyond the low PC_W bits means it wrapped.
    always_comb begin
        if (s1_mode == BT_ABS) exact = s1_off;
        else                   exact = $signed(SW'(s1_base)) + s1_off;
    end

    assign s1_wrap = exact[SW-1] | (|exact[SW-2:PC_W]);
    assign s2_in   = {s1_mode == BT_RSVD, s1_wrap, exact[PC_W-1:0]};

    bt_pipe_stage #(.W(P2_W)) u_stage2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .up_valid   (s1_valid),
        .up_ready_c (s2_ready),
        .up_data    (s2_in),
        .dn_valid   (out_valid),
        .dn_ready   (out_ready),
        .dn_data    (s2_data)
    );

    assign {illegal, wrap, BT} = s2_data;

endmodule

// File: tb/tb_branch_target_unit.sv
// Randomised and directed checks of branch_target_unit (SHIFT=0 and SHIFT=2 instances).
module tb_branch_target_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [1:0]  mode;
    logic [15:0] immediate;
    logic [7:0]  program_counter;
    logic [7:0]  reg_base;
    logic        flush;
    logic        out_ready;

    logic        in_ready0, out_valid0, wrap0, ill0;
    logic [7:0]  bt0;
    logic        in_ready2, out_valid2, wrap2, ill2;
    logic [7:0]  bt2;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        int         t;
        logic [9:0] e0;
        logic [9:0] e2;
    } ent_t;

    ent_t q[$];

    branch_target_unit #(.PC_W(8), .IMM_W(16), .SHIFT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .mode(mode), .immediate(immediate), .program_counter(program_counter),
        .reg_base(reg_base), .flush(flush), .out_valid(out_valid0),
        .out_ready(out_ready), .BT(bt0), .wrap(wrap0), .illegal(ill0)
    );

    branch_target_unit #(.PC_W(8), .IMM_W(16), .SHIFT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .mode(mode), .immediate(immediate), .program_counter(program_counter),
        .reg_base(reg_base), .flush(flush), .out_valid(out_valid2),
        .out_ready(out_ready), .BT(bt2), .wrap(wrap2), .illegal(ill2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: exact integer target, then reduce; returns {illegal, wrap, bt}.
    function automatic logic [9:0] model(input logic [1:0] m, input logic [15:0] imm,
                                         input logic [7:0] pc, input logic [7:0] rb,
                                         input int sh);
        longint off;
        longint ex;
        off = longint'($signed(imm)) * longint'(1 << sh);
        if (m == 2'd1)      ex = off;
        else if (m == 2'd2) ex = off + longint'(rb);
        else                ex = off + longint'(pc);
        return {m == 2'd3, (ex < 0) || (ex > 255), ex[7:0]};
    endfunction

    logic ev;
    logic ir;

    // Scoreboard: in-flight requests in order; head is visible two cycles after acceptance.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            chk("rst_out_valid", 32'(out_valid0), 32'd0);
            chk("rst_out_valid_s2", 32'(out_valid2), 32'd0);
            chk("rst_bt", 32'(bt0), 32'd0);
            chk("rst_wrap", 32'(wrap0), 32'd0);
            chk("rst_illegal", 32'(ill0), 32'd0);
            chk("rst_in_ready", 32'(in_ready0), 32'd1);
        end else begin
            ev = (q.size() > 0) && (q[0].t + 2 <= cyc);
            ir = (q.size() < 2) || out_ready;
            chk("out_valid", 32'(out_valid0), 32'(ev));
            chk("out_valid_s2", 32'(out_valid2), 32'(ev));
            chk("in_ready", 32'(in_ready0), 32'(ir));
            chk("in_ready_s2", 32'(in_ready2), 32'(ir));
            if (ev) begin
                chk("bt", 32'(bt0), 32'(q[0].e0[7:0]));
                chk("wrap", 32'(wrap0), 32'(q[0].e0[8]));
                chk("illegal", 32'(ill0), 32'(q[0].e0[9]));
                chk("bt_s2", 32'(bt2), 32'(q[0].e2[7:0]));
                chk("wrap_s2", 32'(wrap2), 32'(q[0].e2[8]));
                chk("illegal_s2", 32'(ill2), 32'(q[0].e2[9]));
            end
            if (flush) begin
                q.delete();
            end else begin
                if (ev && out_ready) void'(q.pop_front());
                if (in_valid && ir)
                    q.push_back('{cyc,
                                  model(mode, immediate, program_counter, reg_base, 0),
                                  model(mode, immediate, program_counter, reg_base, 2)});
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] m, input logic [15:0] imm,
                        input logic [7:0] pc, input logic [7:0] rb);
        logic ok;
        ok = 1'b0;
        in_valid = 1'b1;
        mode = m; immediate = imm; program_counter = pc; reg_base = rb;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready0;
            step();
        end
        in_valid = 1'b0;
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic count_outs(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (out_valid0 && out_ready) n++;
            step();
        end
    endtask

    int   acc;
    int   nout;
    logic [7:0] held;

    initial begin
        rst_n = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        mode = 2'd0; immediate = '0; program_counter = '0; reg_base = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Hand-computed values pinning the reference model.
        chk("pin_rel0", 32'(model(2'd0, 16'h1234, 8'h80, 8'h00, 0)), 32'h1B4);
        chk("pin_rel1", 32'(model(2'd0, 16'hFFFF, 8'h84, 8'h00, 0)), 32'h083);
        chk("pin_rel2", 32'(model(2'd0, 16'h7FFF, 8'h88, 8'h00, 0)), 32'h187);
        chk("pin_rel3", 32'(model(2'd0, 16'h0000, 8'h8C, 8'h00, 0)), 32'h08C);
        chk("pin_rel4", 32'(model(2'd0, 16'h8000, 8'h90, 8'h00, 0)), 32'h190);
        chk("pin_abs0", 32'(model(2'd1, 16'h00F0, 8'h55, 8'h00, 0)), 32'h0F0);
        chk("pin_abs1", 32'(model(2'd1, 16'hFFFE, 8'h55, 8'h00, 0)), 32'h1FE);
        chk("pin_reg",  32'(model(2'd2, 16'hFFF0, 8'h77, 8'h10, 0)), 32'h000);
        chk("pin_rsvd", 32'(model(2'd3, 16'h0004, 8'h20, 8'h00, 0)), 32'h224);
        chk("pin_sh2a", 32'(model(2'd0, 16'hFFFF, 8'h40, 8'h00, 2)), 32'h03C);
        chk("pin_sh2b", 32'(model(2'd0, 16'h0030, 8'h40, 8'h00, 2)), 32'h100);

        // Directed vectors, back-to-back with the consumer always ready.
        send(2'd0, 16'h1234, 8'h80, 8'h00);
        send(2'd0, 16'hFFFF, 8'h84, 8'h00);
        send(2'd0, 16'h7FFF, 8'h88, 8'h00);
        send(2'd0, 16'h0000, 8'h8C, 8'h00);
        send(2'd0, 16'h8000, 8'h90, 8'h00);
        send(2'd1, 16'h00F0, 8'h00, 8'h00);
        send(2'd1, 16'hFFFE, 8'h00, 8'h00);
        send(2'd2, 16'hFFF0, 8'h00, 8'h10);
        send(2'd3, 16'h0004, 8'h20, 8'h00);
        send(2'd0, 16'hFFFF, 8'h40, 8'h00);
        send(2'd0, 16'h0030, 8'h40, 8'h00);
        repeat (4) step();

        // Backpressure: four offers, two fit.
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; mode = 2'd0;
            immediate = 16'(i * 3 + 1); program_counter = 8'(8'h10 * i);
            @(negedge clk);
            if (in_ready0) acc++;
            step();
        end
        in_valid = 1'b0;
        chk("bp_accepted", 32'(acc), 32'd2);
        @(negedge clk);
        chk("bp_in_ready_low", 32'(in_ready0), 32'd0);
        held = bt0;
        step();
        @(negedge clk);
        chk("bp_bt_stable", 32'(bt0), 32'(held));
        step();
        out_ready = 1'b1;
        count_outs(5, nout);
        chk("bp_drained", 32'(nout), 32'd2);

        // Flush with two in flight and a concurrent request.
        out_ready = 1'b0;
        send(2'd0, 16'h0001, 8'h01, 8'h00);
        send(2'd0, 16'h0002, 8'h02, 8'h00);
        in_valid = 1'b1; flush = 1'b1; immediate = 16'h0003;
        step();
        in_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", 32'(out_valid0), 32'd0);
        step();
        out_ready = 1'b1;
        send(2'd2, 16'h0005, 8'h00, 8'h33);
        count_outs(4, nout);
        chk("flush_after_one", 32'(nout), 32'd1);

        // Asynchronous reset with a wrapping, illegal result on the output.
        out_ready = 1'b0;
        send(2'd3, 16'hFFFF, 8'h00, 8'h00);
        send(2'd3, 16'hFFFF, 8'h00, 8'h00);
        step();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid0), 32'd0);
        chk("arst_bt", 32'(bt0), 32'd0);
        chk("arst_wrap", 32'(wrap0), 32'd0);
        chk("arst_illegal", 32'(ill0), 32'd0);
        chk("arst_illegal_s2", 32'(ill2), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready0), 32'd1);
        chk("post_rst_out_valid", 32'(out_valid0), 32'd0);
        step();

        // Random traffic against the scoreboard.
        for (int i = 0; i < 2000; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 49) == 0);
            mode      = 2'($urandom_range(0, 3));
            immediate = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($signed(8'($urandom)));
            program_counter = 8'($urandom);
            reg_base        = 8'($urandom);
            step();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
